// File: rtl/axis_pkg.sv
// Shared definitions for the AXI-Stream arbitrated mux: arbiter FSM states and
// the bit layout of one beat as it is stored in the output skid register.
package axis_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    // Stored beat layout, LSB first: tdata | tkeep | tlast | tuser.
    function automatic int keep_offset(input int data_width);
        return data_width;
    endfunction

    function automatic int last_offset(input int data_width, input int keep_width);
        return data_width + keep_width;
    endfunction

    function automatic int user_offset(input int data_width, input int keep_width);
        return data_width + keep_width + 1;
    endfunction

    function automatic int packed_width(input int data_width, input int keep_width,
                                        input int user_width);
        return data_width + keep_width + 1 + user_width;
    endfunction

endpackage

// File: rtl/axis_arb_mux_if.sv
// Bundle of the merged AXI-Stream ports of axis_arb_mux: packed per-input slave
// side, single master side and the grant status outputs.
interface axis_arb_mux_if #(
    parameter int S_COUNT    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int KEEP_WIDTH = (DATA_WIDTH + 7) / 8,
    parameter int USER_WIDTH = 1
);
    localparam int IW = $clog2(S_COUNT);

    logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata;
    logic [S_COUNT*KEEP_WIDTH-1:0] s_axis_tkeep;
    logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser;
    logic [S_COUNT-1:0]            s_axis_tvalid;
    logic [S_COUNT-1:0]            s_axis_tlast;
    logic [S_COUNT-1:0]            s_axis_tready;

    logic [DATA_WIDTH-1:0]         m_axis_tdata;
    logic [KEEP_WIDTH-1:0]         m_axis_tkeep;
    logic [USER_WIDTH-1:0]         m_axis_tuser;
    logic                          m_axis_tvalid;
    logic                          m_axis_tlast;
    logic                          m_axis_tready;

    logic [IW-1:0]                 grant_index;
    logic                          grant_valid;

    // The mux itself.
    modport slave (
        input  s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tvalid, s_axis_tlast,
        input  m_axis_tready,
        output s_axis_tready,
        output m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tvalid, m_axis_tlast,
        output grant_index, grant_valid
    );

    // The environment around the mux: sources and sink.
    modport master (
        output s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tvalid, s_axis_tlast,
        output m_axis_tready,
        input  s_axis_tready,
        input  m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tvalid, m_axis_tlast,
        input  grant_index, grant_valid
    );

endinterface

// File: rtl/axis_rr_arb.sv
// Round-robin priority encoder: picks the first requester strictly after
// last_grant in ascending order, wrapping from S_COUNT-1 back to 0.
module axis_rr_arb
    import axis_pkg::*;
#(
    parameter int S_COUNT = 4,
    parameter int IW      = $clog2(S_COUNT)
)(
    input  logic [S_COUNT-1:0] request,
    input  logic [IW-1:0]      last_grant,
    output logic [IW-1:0]      grant,
    output logic               grant_valid
);

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        for (int k = S_COUNT; k >= 1; k--) begin
            int idx;
            idx         = int'(last_grant) + k;
            idx         = (idx >= S_COUNT) ? (idx - S_COUNT) : idx;
            grant       = request[idx] ? IW'(idx) : grant;
            grant_valid = grant_valid | request[idx];
        end
    end

endmodule

// File: rtl/axis_arb_mux.sv
// Frame-atomic round-robin AXI-Stream mux: an IDLE/BUSY grant FSM feeding a
// two-entry skid register whose input ready is simply !expansion_valid.
module axis_arb_mux
    import axis_pkg::*;
#(
    parameter int S_COUNT     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int KEEP_ENABLE = int'(DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = (DATA_WIDTH + 7) / 8,
    parameter int LAST_ENABLE = 1,
    parameter int USER_ENABLE = 0,
    parameter int USER_WIDTH  = 1
)(
    input  logic          clk,
    input  logic          rst,
    axis_arb_mux_if.slave bus
);

    localparam int IW = $clog2(S_COUNT);
    localparam int KO = keep_offset(DATA_WIDTH);
    localparam int LO = last_offset(DATA_WIDTH, KEEP_WIDTH);
    localparam int UO = user_offset(DATA_WIDTH, KEEP_WIDTH);
    localparam int W  = packed_width(DATA_WIDTH, KEEP_WIDTH, USER_WIDTH);

    arb_state_e      state_r, state_s;
    logic [IW-1:0]   grant_index_r, grant_index_s;
    logic [IW-1:0]   last_grant_r, last_grant_s;
    logic [IW-1:0]   arb_grant_s;
    logic            arb_valid_s;
    int              sel_s;
    logic [W-1:0]    beat_s, out_s;
    logic            in_valid_s, in_ready_s, accept_s;
    logic [S_COUNT-1:0] s_ready_s;
    logic [W-1:0]    pri_r, exp_r;
    logic            pri_v_r, exp_v_r;

    axis_rr_arb #(.S_COUNT(S_COUNT)) u_arb (
        .request     (bus.s_axis_tvalid),
        .last_grant  (last_grant_r),
        .grant       (arb_grant_s),
        .grant_valid (arb_valid_s)
    );

    assign sel_s      = int'(grant_index_r);
    assign in_ready_s = !exp_v_r;
    assign accept_s   = in_valid_s && in_ready_s;

    // Select the granted input and fill disabled sideband fields with their fixed values.
    always_comb begin
        beat_s                     = '0;
        beat_s[DATA_WIDTH-1:0]     = bus.s_axis_tdata[sel_s*DATA_WIDTH +: DATA_WIDTH];
        beat_s[KO +: KEEP_WIDTH]   = (KEEP_ENABLE != 0) ?
                                     bus.s_axis_tkeep[sel_s*KEEP_WIDTH +: KEEP_WIDTH] :
                                     {KEEP_WIDTH{1'b1}};
        beat_s[LO]                 = (LAST_ENABLE != 0) ? bus.s_axis_tlast[sel_s] : 1'b1;
        beat_s[UO +: USER_WIDTH]   = (USER_ENABLE != 0) ?
                                     bus.s_axis_tuser[sel_s*USER_WIDTH +: USER_WIDTH] :
                                     {USER_WIDTH{1'b0}};
        in_valid_s                 = (state_r == ST_BUSY) && bus.s_axis_tvalid[sel_s];
    end

    // Only the granted input ever sees ready, and only while BUSY.
    always_comb begin
        s_ready_s = '0;
        if (state_r == ST_BUSY) begin
            s_ready_s[sel_s] = in_ready_s;
        end else begin
            s_ready_s = '0;
        end
    end

    // Grant FSM next-state: arbitrate in IDLE, release after the accepted tlast beat.
    always_comb begin
        state_s       = state_r;
        grant_index_s = grant_index_r;
        last_grant_s  = last_grant_r;
        case (state_r)
            ST_IDLE: begin
                if (arb_valid_s) begin
                    state_s       = ST_BUSY;
                    grant_index_s = arb_grant_s;
                end else begin
                    state_s       = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (accept_s && beat_s[LO]) begin
                    state_s      = ST_IDLE;
                    last_grant_s = grant_index_r;
                end else begin
                    state_s      = ST_BUSY;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Grant FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= ST_IDLE;
            grant_index_r <= '0;
            last_grant_r  <= IW'(S_COUNT - 1);
        end else begin
            state_r       <= state_s;
            grant_index_r <= grant_index_s;
            last_grant_r  <= last_grant_s;
        end
    end

    // Skid register: on a stall the older primary beat moves to expansion, which then drives m_axis.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pri_r   <= '0;
            exp_r   <= '0;
            pri_v_r <= 1'b0;
            exp_v_r <= 1'b0;
        end else if (exp_v_r) begin
            if (bus.m_axis_tready) begin
                exp_v_r <= 1'b0;
            end
        end else if (accept_s) begin
            pri_r   <= beat_s;
            pri_v_r <= 1'b1;
            if (pri_v_r && !bus.m_axis_tready) begin
                exp_r   <= pri_r;
                exp_v_r <= 1'b1;
            end
        end else if (bus.m_axis_tready) begin
            pri_v_r <= 1'b0;
        end
    end

    assign out_s             = exp_v_r ? exp_r : pri_r;
    assign bus.m_axis_tvalid = pri_v_r | exp_v_r;
    assign bus.m_axis_tdata  = out_s[DATA_WIDTH-1:0];
    assign bus.m_axis_tkeep  = out_s[KO +: KEEP_WIDTH];
    assign bus.m_axis_tlast  = out_s[LO];
    assign bus.m_axis_tuser  = out_s[UO +: USER_WIDTH];
    assign bus.s_axis_tready = s_ready_s;
    assign bus.grant_index   = grant_index_r;
    assign bus.grant_valid   = (state_r == ST_BUSY);

endmodule

// File: doc/axis_arb_mux.md
AXIS_ARB_MUX -- requirements
Module: axis_arb_mux

Interface
REQ-001 The block SHALL have parameter S_COUNT, default 4: number of AXI-Stream slave inputs (2..16).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8: tdata width per stream.
REQ-003 The block SHALL have parameter KEEP_ENABLE, default (DATA_WIDTH>8): tkeep carried when 1.
REQ-004 The block SHALL have parameter KEEP_WIDTH, default (DATA_WIDTH+7)/8: tkeep width.
REQ-005 The block SHALL have parameter LAST_ENABLE, default 1: when 0, every beat is a one-beat frame.
REQ-006 The block SHALL have parameter USER_ENABLE, default 0, and USER_WIDTH, default 1: tuser carried when enabled.
REQ-007 The block SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-008 The block SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-009 The block SHALL have ports s_axis_tdata/tkeep/tuser, input, S_COUNT x DATA_WIDTH/KEEP_WIDTH/USER_WIDTH: packed per-input payload, input i at slice i.
REQ-010 The block SHALL have ports s_axis_tvalid, s_axis_tlast (input) and s_axis_tready (output), each S_COUNT: per-input handshake and frame end.
REQ-011 The block SHALL have ports m_axis_tdata/tkeep/tuser, output, DATA_WIDTH/KEEP_WIDTH/USER_WIDTH: merged payload.
REQ-012 The block SHALL have ports m_axis_tvalid, m_axis_tlast (output) and m_axis_tready (input), each 1.
REQ-013 The block SHALL have port grant_index, output, $clog2(S_COUNT): currently granted input.
REQ-014 The block SHALL have port grant_valid, output, 1: high while a frame is granted.

Function
REQ-015 The FSM SHALL have two states: IDLE (no grant) and BUSY (grant held by grant_index).
REQ-016 In IDLE with any s_axis_tvalid high, the next requester after last_grant in ascending order, wrapping at S_COUNT-1 to 0, SHALL be granted; the state moves to BUSY on the next edge.
REQ-017 No s_axis_tready bit SHALL assert in IDLE, and only bit grant_index SHALL assert in BUSY.
REQ-018 In BUSY, s_axis_tready[grant_index] SHALL equal the internal output-stage ready.
REQ-019 An accepted beat with tlast=1 (or any accepted beat if LAST_ENABLE=0) SHALL move BUSY to IDLE, set last_grant to grant_index and deassert grant_valid on the next edge.
REQ-020 Grants SHALL be frame-atomic: no regrant before the tlast beat is accepted, regardless of other requests.
REQ-021 Between frames there SHALL be exactly one IDLE cycle; sustained throughput within a frame SHALL be one beat per cycle.
REQ-022 Output stage SHALL be a two-entry skid register (primary + expansion); its ready SHALL be registered (!expansion_valid); m_axis_tvalid SHALL be primary_valid OR expansion_valid; the expansion entry SHALL take precedence on m_axis.
REQ-023 Latency SHALL be: first beat on m_axis two cycles after s_axis_tvalid rises in IDLE with m_axis_tready=1.
REQ-024 Disabled fields SHALL drive m_axis_tkeep all ones, m_axis_tlast 1 when LAST_ENABLE=0, and m_axis_tuser 0.
REQ-025 The granted input dropping tvalid mid-frame SHALL hold the grant (BUSY) indefinitely; no timeout.
REQ-026 m_axis_tready low SHALL hold m_axis payload and tvalid stable; no beat SHALL be lost or duplicated.

Reset
REQ-027 Asserting rst (low) SHALL immediately force: state IDLE, last_grant S_COUNT-1, grant_valid 0, grant_index 0, all s_axis_tready 0, both skid valids 0, m_axis_tvalid 0; an in-flight frame is discarded.
REQ-028 Deassertion SHALL be synchronised externally; the first grant after reset SHALL go to the lowest-indexed requester.

Structure
REQ-029 The FSM state enum and the field offset constants (KEEP/LAST/USER offset, packed WIDTH) SHALL live in shared package axis_pkg.
REQ-030 The round-robin priority encoder (request vector, last_grant -> grant, grant_valid) SHALL be sub-module axis_rr_arb; the skid stage stays inline.

Verification
REQ-031 Reset, then inputs 0 and 2 each present a 3-beat frame (0x10-0x12, 0x20-0x22), m_axis_tready=1 -> m_axis 0x10,0x11,0x12,0x20,0x21,0x22 with one bubble between frames.
REQ-032 All four inputs continuously request 1-beat frames -> grant_index sequence 0,1,2,3,0,...
REQ-033 Input 1 mid-frame (beat 2 of 4) while input 3 requests -> input 3 is not granted until beat 4 (tlast) of input 1 is accepted.
REQ-034 m_axis_tready low for 5 cycles during a 6-beat frame -> all 6 beats delivered in order; m_axis data stable while stalled; s_axis_tready drops within one cycle.
REQ-035 rst asserted mid-frame with m_axis_tvalid=1 -> m_axis_tvalid, grant_valid and all s_axis_tready 0 immediately; first post-reset grant goes to lowest requesting index.
